// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute phases and drives datapath selects and enables.
module mips_multicycle_control #(
  parameter bit RESUME_ON_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zeroFlag,
  output logic [3:0] aluOperation,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic [3:0] state,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next       = S_TRAP;
    aluOperation = 4'b0000;
    aluSrcA      = 1'b0;
    aluSrcB      = 2'b00;
    pcWrite      = 1'b0;
    pcSrc        = 2'b00;
    iOrD         = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    irWrite      = 1'b0;
    regWrite     = 1'b0;
    regDst       = 1'b0;
    memToReg     = 1'b0;
    illegalOp    = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        memRead      = 1'b1;
        irWrite      = 1'b1;
        aluSrcB      = 2'b01;
        aluOperation = 4'b0001;
        pcWrite      = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB      = 2'b11;
        aluOperation = 4'b0001;
        case (opcode)
          OP_R:          w_next = S_REXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_ADDI, OP_ANDI,
          OP_ORI, OP_SLTI: w_next = S_IEXEC;
          default:       w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluSrcA      = 1'b1;
        aluSrcB      = 2'b10;
        aluOperation = 4'b0001;
        w_next       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iOrD    = 1'b1;
        memRead = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        iOrD     = 1'b1;
        memWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_REXEC: begin
        aluSrcA = 1'b1;
        w_next  = S_RWB;
        case (funct)
          6'b100000: aluOperation = 4'b0001;
          6'b100010: aluOperation = 4'b0010;
          6'b011000: aluOperation = 4'b0011;
          6'b011010: aluOperation = 4'b0100;
          6'b100100: aluOperation = 4'b0101;
          6'b100101: aluOperation = 4'b0110;
          6'b100111: aluOperation = 4'b0111;
          6'b101010: aluOperation = 4'b1000;
          6'b100110: aluOperation = 4'b1001;
          default:   w_next = S_TRAP;
        endcase
      end
      S_RWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_IEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = S_IWB;
        case (opcode)
          OP_ADDI: aluOperation = 4'b0001;
          OP_ANDI: aluOperation = 4'b0101;
          OP_ORI:  aluOperation = 4'b0110;
          OP_SLTI: aluOperation = 4'b1000;
          default: aluOperation = 4'b0000;
        endcase
      end
      S_IWB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA      = 1'b1;
        aluOperation = 4'b0010;
        pcSrc        = 2'b01;
        // bne differs from beq only in opcode bit 0
        pcWrite      = opcode[0] ? ~zeroFlag : zeroFlag;
        w_next       = S_FETCH;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b10;
        w_next  = S_FETCH;
      end
      S_TRAP: begin
        illegalOp = 1'b1;
        w_next    = RESUME_ON_TRAP ? S_FETCH : S_TRAP;
      end
      default: w_next = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control against a phase-table model.
// A second instance with RESUME_ON_TRAP=1 shares all stimulus.
module tb_mips_multicycle_control;

  localparam int FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4;
  localparam int MEMWB = 5, MEMWR = 6, REXEC = 7, RWB = 8;
  localparam int BRANCH = 9, JUMP = 10, IEXEC = 11, IWB = 12;
  localparam int TRAP = 13;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zeroFlag = 1'b0;

  logic [3:0] aluOperation, state;
  logic       aluSrcA, pcWrite, iOrD, memRead, memWrite;
  logic       irWrite, regWrite, regDst, memToReg, illegalOp;
  logic [1:0] aluSrcB, pcSrc;

  logic [3:0] r_aluOperation, r_state;
  logic       r_aluSrcA, r_pcWrite, r_iOrD, r_memRead, r_memWrite;
  logic       r_irWrite, r_regWrite, r_regDst, r_memToReg, r_illegalOp;
  logic [1:0] r_aluSrcB, r_pcSrc;

  int n_tests = 0;
  int n_fail = 0;
  int path[$];

  mips_multicycle_control #(.RESUME_ON_TRAP(1'b0)) dut (
    .clk(clk), .resetN(resetN), .opcode(opcode), .funct(funct),
    .zeroFlag(zeroFlag), .aluOperation(aluOperation), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcWrite(pcWrite), .pcSrc(pcSrc), .iOrD(iOrD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .state(state), .illegalOp(illegalOp)
  );

  mips_multicycle_control #(.RESUME_ON_TRAP(1'b1)) dut_r (
    .clk(clk), .resetN(resetN), .opcode(opcode), .funct(funct),
    .zeroFlag(zeroFlag), .aluOperation(r_aluOperation),
    .aluSrcA(r_aluSrcA), .aluSrcB(r_aluSrcB), .pcWrite(r_pcWrite),
    .pcSrc(r_pcSrc), .iOrD(r_iOrD), .memRead(r_memRead),
    .memWrite(r_memWrite), .irWrite(r_irWrite), .regWrite(r_regWrite),
    .regDst(r_regDst), .memToReg(r_memToReg), .state(r_state),
    .illegalOp(r_illegalOp)
  );

  always #5 clk = ~clk;

  wire [17:0] w_outs = {aluOperation, aluSrcA, aluSrcB, pcWrite, pcSrc,
                        iOrD, memRead, memWrite, irWrite, regWrite,
                        regDst, memToReg, illegalOp};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd1;
      6'h22: return 4'd2;
      6'h18: return 4'd3;
      6'h1a: return 4'd4;
      6'h24: return 4'd5;
      6'h25: return 4'd6;
      6'h27: return 4'd7;
      6'h2a: return 4'd8;
      6'h26: return 4'd9;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08: return 4'd1;
      6'h0c: return 4'd5;
      6'h0d: return 4'd6;
      6'h0a: return 4'd8;
      default: return 4'd15;
    endcase
  endfunction

  // Expected state sequence from FETCH up to (not including) next FETCH
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    path = {FETCH, DECODE};
    if (op == 6'h00) begin
      path.push_back(REXEC);
      path.push_back(r_alu(fn) == 4'd15 ? TRAP : RWB);
    end else if (op == 6'h23) path = {path, MEMADR, MEMRD, MEMWB};
    else if (op == 6'h2b)     path = {path, MEMADR, MEMWR};
    else if (op == 6'h04 || op == 6'h05) path.push_back(BRANCH);
    else if (op == 6'h02)     path.push_back(JUMP);
    else if (i_alu(op) != 4'd15) path = {path, IEXEC, IWB};
    else                      path.push_back(TRAP);
  endtask

  function automatic logic [17:0] model_out(input int s,
      input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [3:0] alu;
    logic [1:0] sb, ps;
    logic sa, pw, iod, mr, mw, irw, rw, rd, m2r, ill;
    {alu, sb, ps, sa, pw, iod, mr, mw, irw, rw, rd, m2r, ill} = '0;
    case (s)
      FETCH:  begin mr = 1; irw = 1; sb = 2'b01; alu = 4'd1; pw = 1; end
      DECODE: begin sb = 2'b11; alu = 4'd1; end
      MEMADR: begin sa = 1; sb = 2'b10; alu = 4'd1; end
      MEMRD:  begin iod = 1; mr = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin iod = 1; mw = 1; end
      REXEC:  begin
        sa = 1;
        alu = (r_alu(fn) == 4'd15) ? 4'd0 : r_alu(fn);
      end
      RWB:    begin rw = 1; rd = 1; end
      IEXEC:  begin sa = 1; sb = 2'b10; alu = i_alu(op); end
      IWB:    rw = 1;
      BRANCH: begin
        sa = 1; alu = 4'd2; ps = 2'b01;
        pw = (op == 6'h04) ? z : !z;
      end
      JUMP:   begin pw = 1; ps = 2'b10; end
      TRAP:   ill = 1;
      default: ;
    endcase
    return {alu, sa, sb, pw, ps, iod, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(w_outs), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_hold", 32'(w_outs), 32'd0);
    end
    resetN = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd0);
  endtask

  task automatic trap_hold();
    chk("trapR_state", 32'(r_state), TRAP);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("trap_state", 32'(state), TRAP);
      chk("trap_ill", 32'(illegalOp), 32'd1);
      if (k == 1) chk("trapR_resume", 32'(r_state), FETCH);
    end
    do_reset();
  endtask

  // zmode: 0/1 forces zeroFlag, 2 randomizes it every cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode);
    build_path(op, fn);
    foreach (path[i]) begin
      @(negedge clk);
      zeroFlag = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      chk("state", 32'(state), path[i]);
      chk("outs", 32'(w_outs), 32'(model_out(path[i], op, fn, zeroFlag)));
      if (i == 0) begin
        opcode = op;
        funct = fn;
      end
    end
    if (path[path.size()-1] == TRAP) trap_hold();
  endtask

  logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                           6'h08, 6'h0c, 6'h0d, 6'h0a};
  logic [5:0] fns [9] = '{6'h20, 6'h22, 6'h18, 6'h1a, 6'h24, 6'h25,
                          6'h27, 6'h2a, 6'h26};

  initial begin
    logic [5:0] op, fn;
    do_reset();
    run_instr(6'h00, 6'h22, 2);
    run_instr(6'h23, 6'h00, 2);
    run_instr(6'h04, 6'h00, 1);
    run_instr(6'h04, 6'h00, 0);
    run_instr(6'h05, 6'h00, 1);
    run_instr(6'h05, 6'h00, 0);
    run_instr(6'h3f, 6'h00, 2);
    run_instr(6'h00, 6'h3f, 2);
    // Async reset while memWrite is active
    build_path(6'h2b, 6'h00);
    foreach (path[i]) begin
      @(negedge clk);
      #1;
      chk("sw_state", 32'(state), path[i]);
      if (i == 0) opcode = 6'h2b;
    end
    chk("mw_high", 32'(memWrite), 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk("mw_async", 32'(memWrite), 32'd0);
    chk("st_async", 32'(state), 32'd0);
    chk("outs_async", 32'(w_outs), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    #1;
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                       : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                       : fns[$urandom_range(0, 8)];
      run_instr(op, fn, 2);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
